// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and constants for the MIPS fetch/redirect path
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JR     = 2'd2,
    SEL_J      = 2'd3
  } sel_t;

  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/branch_target_adder.sv
// rtl/branch_target_adder.sv - modular 32-bit add of branch PC+4 and word-aligned offset
module branch_target_adder (
  input  logic [31:0] pc4,
  input  logic [31:0] offset,
  output logic [31:0] target
);

  // Carry out is intentionally discarded so targets wrap around the address space.
  assign target = pc4 + offset;

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - PC register with branch/jump/JR redirect, stall buffering and flush
module pc_redirect_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchPC4,
  input  logic [31:0] ShiftedOffset,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Flush,
  output logic        RedirectPending,
  output logic        AlignFault
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t      state_q, state_n;
  sel_t        sel;
  logic [31:0] pc_q, pc_n;
  logic [31:0] pend_q, pend_n;
  logic        pend_br_q, pend_br_n;
  logic [2:0]  cnt_q, cnt_n;
  logic        flush_q, pendflag_q;
  logic        align_q, align_n;
  logic [31:0] branch_target;
  logic [31:0] req_target;
  logic [31:0] hold_target;

  branch_target_adder u_bta (
    .pc4    (BranchPC4),
    .offset (ShiftedOffset),
    .target (branch_target)
  );

  // The branch in EX is older than any jump in ID, so it wins.
  always_comb begin
    sel = SEL_NONE;
    if (BranchTaken)  sel = SEL_BRANCH;
    else if (JumpReg) sel = SEL_JR;
    else if (Jump)    sel = SEL_J;
  end

  always_comb begin
    req_target = 32'd0;
    case (sel)
      SEL_BRANCH: req_target = branch_target;
      SEL_JR:     req_target = RegTarget;
      SEL_J:      req_target = JumpTarget;
      default:    req_target = 32'd0;
    endcase
  end

  // Only a branch may displace a buffered jump/JR; a buffered branch is never replaced.
  assign hold_target = (BranchTaken && !pend_br_q) ? branch_target : pend_q;

  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    pend_n    = pend_q;
    pend_br_n = pend_br_q;
    cnt_n     = cnt_q;
    align_n   = align_q;
    case (state_q)
      ST_RUN: begin
        if (sel != SEL_NONE) begin
          if (!Stall) begin
            pc_n    = req_target;
            state_n = ST_FLUSH;
            cnt_n   = FLUSH_INIT;
            align_n = align_q | (req_target[1:0] != 2'b00);
          end else begin
            pend_n    = req_target;
            pend_br_n = (sel == SEL_BRANCH);
            state_n   = ST_HOLD;
          end
        end else if (!Stall) begin
          pc_n = pc_q + PC_INCR;
        end
      end
      ST_HOLD: begin
        if (Stall) begin
          pend_n    = hold_target;
          pend_br_n = pend_br_q | BranchTaken;
        end else begin
          pc_n    = hold_target;
          state_n = ST_FLUSH;
          cnt_n   = FLUSH_INIT;
          align_n = align_q | (hold_target[1:0] != 2'b00);
        end
      end
      ST_FLUSH: begin
        if (!Stall) begin
          pc_n  = pc_q + PC_INCR;
          cnt_n = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_n = ST_RUN;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_q     <= 32'd0;
      pend_br_q  <= 1'b0;
      cnt_q      <= 3'd0;
      flush_q    <= 1'b0;
      pendflag_q <= 1'b0;
      align_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      pend_q     <= pend_n;
      pend_br_q  <= pend_br_n;
      cnt_q      <= cnt_n;
      flush_q    <= (state_n == ST_FLUSH);
      pendflag_q <= (state_n == ST_HOLD);
      align_q    <= align_n;
    end
  end

  assign PC              = pc_q;
  assign PCPlus4         = pc_q + PC_INCR;
  assign Flush           = flush_q;
  assign RedirectPending = pendflag_q;
  assign AlignFault      = align_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - directed vector bench for pc_redirect_unit
module tb_pc_redirect_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchPC4 = 32'd0;
  logic [31:0] ShiftedOffset = 32'd0;
  logic        Jump = 1'b0;
  logic [31:0] JumpTarget = 32'd0;
  logic        JumpReg = 1'b0;
  logic [31:0] RegTarget = 32'd0;
  logic [31:0] PC, PCPlus4;
  logic        Flush, RedirectPending, AlignFault;

  int total = 0;
  int bad = 0;

  pc_redirect_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Stall           (Stall),
    .BranchTaken     (BranchTaken),
    .BranchPC4       (BranchPC4),
    .ShiftedOffset   (ShiftedOffset),
    .Jump            (Jump),
    .JumpTarget      (JumpTarget),
    .JumpReg         (JumpReg),
    .RegTarget       (RegTarget),
    .PC              (PC),
    .PCPlus4         (PCPlus4),
    .Flush           (Flush),
    .RedirectPending (RedirectPending),
    .AlignFault      (AlignFault)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        stall;
    logic        bt;
    logic [31:0] bpc4;
    logic [31:0] off;
    logic        j;
    logic [31:0] jt;
    logic        jr;
    logic [31:0] rt;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_pend;
    logic        e_align;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic stall, logic bt, logic [31:0] bpc4, logic [31:0] off,
                              logic j, logic [31:0] jt, logic jr, logic [31:0] rt,
                              logic [31:0] e_pc, logic e_flush, logic e_pend, logic e_align);
    vec_t v;
    v.stall = stall; v.bt = bt; v.bpc4 = bpc4; v.off = off;
    v.j = j; v.jt = jt; v.jr = jr; v.rt = rt;
    v.e_pc = e_pc; v.e_flush = e_flush; v.e_pend = e_pend; v.e_align = e_align;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Stall = 0; BranchTaken = 0; Jump = 0; JumpReg = 0;
    BranchPC4 = 0; ShiftedOffset = 0; JumpTarget = 0; RegTarget = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    // idle vector: stall, bt, bpc4, off, j, jt, jr, rt, exp pc, flush, pend, align
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'(4 * i), 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h1C, 32'h40, 0, 0, 0, 0, 32'h5C, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h60, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h64, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h10, 32'hFFFF_FFF8, 1, 32'h400, 0, 0, 32'h08, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0C, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h300, 0, 0, 32'h10, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'h70, 32'h10, 0, 0, 0, 0, 32'h10, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h84, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h88, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h102, 32'h102, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h106, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h10A, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h200, 0, 0, 32'h200, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h204, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h208, 0, 0, 1));
    // wrap-around branch target
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 32'h8, 0, 0, 0, 0, 32'h04, 1, 0, 1));
    // redirect during flush is ignored
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h500, 0, 0, 32'h08, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h08, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0C, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0C, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h40, 0, 0, 32'h40, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 1, 0, 1));

    idle_inputs();
    Reset = 0;
    #1;
    chk("reset pc", PC, 32'h0);
    chk("reset flush", {31'd0, Flush}, 32'd0);
    chk("reset pend", {31'd0, RedirectPending}, 32'd0);
    chk("reset align", {31'd0, AlignFault}, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1;

    foreach (vecs[i]) begin
      Stall = vecs[i].stall; BranchTaken = vecs[i].bt;
      BranchPC4 = vecs[i].bpc4; ShiftedOffset = vecs[i].off;
      Jump = vecs[i].j; JumpTarget = vecs[i].jt;
      JumpReg = vecs[i].jr; RegTarget = vecs[i].rt;
      step();
      chk($sformatf("v%0d pc", i), PC, vecs[i].e_pc);
      chk($sformatf("v%0d pcplus4", i), PCPlus4, vecs[i].e_pc + 32'd4);
      chk($sformatf("v%0d flush", i), {31'd0, Flush}, {31'd0, vecs[i].e_flush});
      chk($sformatf("v%0d pend", i), {31'd0, RedirectPending}, {31'd0, vecs[i].e_pend});
      chk($sformatf("v%0d align", i), {31'd0, AlignFault}, {31'd0, vecs[i].e_align});
    end

    // async reset mid-flush (counter at 1) takes effect without a clock edge
    idle_inputs();
    #1 Reset = 0;
    #1;
    chk("midflush rst pc", PC, 32'h0);
    chk("midflush rst flush", {31'd0, Flush}, 32'd0);
    chk("midflush rst pend", {31'd0, RedirectPending}, 32'd0);
    chk("midflush rst align", {31'd0, AlignFault}, 32'd0);
    @(negedge Clk);
    Reset = 1;

    // pending flag is registered: no same-cycle response to the request
    Stall = 1; BranchTaken = 1; BranchPC4 = 32'h100; ShiftedOffset = 32'h0;
    #1;
    chk("pend comb path", {31'd0, RedirectPending}, 32'd0);
    @(negedge Clk);
    chk("hold pend", {31'd0, RedirectPending}, 32'd1);
    chk("hold pc", PC, 32'h0);
    idle_inputs();
    Stall = 1;
    #1 Reset = 0;
    #1;
    chk("midhold rst pend", {31'd0, RedirectPending}, 32'd0);
    @(negedge Clk);
    Reset = 1;
    Stall = 0;
    step();
    chk("after hold rst pc", PC, 32'h4);
    chk("after hold rst flush", {31'd0, Flush}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
